turn_cmd_encoder: RTL and testbench
===================================

TURN_CMD_ENCODER -- requirements
Module: turn_cmd_encoder

Interface
REQ-001 Parameters SHALL be, one per line:
  DEB_CNT, 2, consecutive equal samples needed to accept a switch change (1..7)
  TURN_MAX, 20, maximum turn-signal duration in clk_2hz cycles before auto-cancel (2..255)
REQ-002 Ports SHALL be, in this order:
  clk_2hz  in  1  2 Hz system tick clock
  rst  in  1  asynchronous, active-low reset
  power_now  in  1  car power present; low forces the idle condition
  state  in  4  one-hot car state: 0001 not started, 0010 starting, 0100 moving, 1000 power-off
  sw_left, sw_right, sw_back, sw_fwd  in  1 each  raw driver switches
  answer  out  4  registered command {left, right, back, fwd}, bit3 = left
  turn_active  out  1  high while in TURN_L, TURN_R or HAZARD
  blink_phase  out  1  lamp phase for the light driver
  cancel_pulse  out  1  one-cycle pulse on turn auto-cancel

Function
REQ-003 Each switch SHALL have its own debouncer. The debounced value changes on the edge where the raw sample has differed from the current debounced value for DEB_CNT consecutive edges. Any mismatch restarts the count.
REQ-004 answer SHALL change on the edge after the debounced change, so raw-to-answer latency is DEB_CNT+1 edges.
REQ-005 drive_ok SHALL be power_now AND (state==0010 OR state==0100). Any other state value, including non-one-hot values, SHALL count as not ok.
REQ-006 The FSM states SHALL be IDLE, TURN_L, TURN_R, COOLDOWN, plus HAZARD when HAZARD_EN is defined.
REQ-007 IDLE -> TURN_L SHALL occur on deb_left & ~deb_right & drive_ok. IDLE -> TURN_R SHALL be symmetric. Both switches high SHALL keep the FSM in IDLE unless HAZARD_EN is defined.
REQ-008 In TURN_L/TURN_R:
  - The timer SHALL clear on entry and increment each cycle.
  - Release of the own switch, or assertion of the opposite switch, SHALL return to IDLE.
  - When timer==TURN_MAX-1, the FSM SHALL go to COOLDOWN and assert cancel_pulse for exactly one cycle.
  - If release and timeout happen in the same cycle, release SHALL win: IDLE, no pulse.
REQ-009 COOLDOWN SHALL last at least 2 cycles. It SHALL exit to IDLE only once deb_left and deb_right are both low, so the driver must release the switch before re-arming.
REQ-010 drive_ok low in any state SHALL force IDLE on the next edge. The timer SHALL clear and no cancel_pulse SHALL be issued.
REQ-011 answer[3] SHALL be 1 only in TURN_L (or HAZARD). answer[2] SHALL be 1 only in TURN_R (or HAZARD).
REQ-012 answer[1:0] SHALL equal {deb_back, deb_fwd} when drive_ok is high, and 00 if both are high or drive_ok is low.
REQ-013 blink_phase SHALL be 1 on the first active cycle and toggle every cycle while turn_active. It SHALL be 0 otherwise.
REQ-014 Timer width SHALL be $clog2(TURN_MAX+1). The timer SHALL saturate and never wrap.

Reset
REQ-015 rst low SHALL asynchronously set the FSM to IDLE, clear all debouncers and counters, and set answer=0000, turn_active=0, blink_phase=0, cancel_pulse=0.
REQ-016 power_now low SHALL apply the same clear synchronously, including the debouncers. A reset mid-turn SHALL require a fresh debounce before re-arming.

Configuration
REQ-017 With HAZARD_EN defined:
  - IDLE with deb_left & deb_right & drive_ok SHALL enter HAZARD.
  - In HAZARD, answer[3:2]=11, there is no timeout, and release of either switch exits to IDLE.
REQ-018 Without HAZARD_EN, the HAZARD state and its logic SHALL be absent, and both switches high SHALL yield answer[3:2]=00.

Structure
REQ-019 The shared package SHALL hold the FSM state enum, the car-state one-hot constants (ST_IDLE=0001, ST_START=0010, ST_MOVE=0100, ST_OFF=1000) and the answer bit-index constants.
REQ-020 The switch debouncer SHALL be a sub-module, sw_debounce (parameter DEB_CNT), instantiated four times.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
  - state=0100, sw_left 0->1 held: answer=1000 at edge 3, blink_phase 1,0,1...; release -> answer 0000 three edges later.
  - sw_right held 25 cycles in state 0100 with TURN_MAX=20: TURN_R for 20 cycles, then cancel_pulse for one cycle, COOLDOWN with answer[2]=0; re-arm only after release.
  - sw_left high for 1 cycle only (glitch): answer stays 0000.
  - state switched to 0001 mid-turn: answer=0000 on the next edge, no cancel_pulse.
  - rst low mid-turn at timer=10: all outputs 0 immediately; after release, left held again -> TURN_L after 3 edges.
  - Both sw_left and sw_right high: answer[3:2]=00 without HAZARD_EN, 11 steady with HAZARD_EN.

Source files
------------

// File: rtl/turn_cmd_encoder_pkg.sv
// Shared types and constants for the turn command encoder; HAZARD_EN adds the hazard state.
// No logic, no latency.
package turn_cmd_encoder_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    TURN_L   = 3'd1,
    TURN_R   = 3'd2,
    COOLDOWN = 3'd3
`ifdef HAZARD_EN
    ,
    HAZARD   = 3'd4
`endif
  } fsm_t;

  // One-hot car state encoding
  localparam logic [3:0] ST_IDLE  = 4'b0001;
  localparam logic [3:0] ST_START = 4'b0010;
  localparam logic [3:0] ST_MOVE  = 4'b0100;
  localparam logic [3:0] ST_OFF   = 4'b1000;

  localparam int ANS_LEFT  = 3;
  localparam int ANS_RIGHT = 2;
  localparam int ANS_BACK  = 1;
  localparam int ANS_FWD   = 0;

endpackage

// File: rtl/turn_cmd_encoder_sw_debounce.sv
// Switch debouncer (module sw_debounce): output follows raw after DEB_CNT consecutive differing samples.
// Latency DEB_CNT edges; no backpressure; clr_i clears synchronously.
module sw_debounce #(
  parameter int DEB_CNT = 2
) (
  input  logic clk_2hz,
  input  logic rst,
  input  logic clr_i,
  input  logic raw_i,
  output logic deb_o
);

  localparam int CW = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;

  logic          deb_q, deb_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (clr_i) begin
      deb_d = 1'b0;
    end else if (raw_i != deb_q) begin
      // Counter holds the number of differing samples already seen
      if (cnt_q == CW'(DEB_CNT - 1)) begin
        deb_d = raw_i;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_2hz or negedge rst) begin
    if (!rst) begin
      deb_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end

  assign deb_o = deb_q;

endmodule

// File: rtl/turn_cmd_encoder.sv
// Turn-signal command encoder: debounced switches -> registered {left,right,back,fwd}; HAZARD_EN adds hazard mode.
// Raw-to-answer latency DEB_CNT+1 edges; no backpressure, outputs update every clk_2hz edge.
module turn_cmd_encoder
  import turn_cmd_encoder_pkg::*;
#(
  parameter int DEB_CNT  = 2,
  parameter int TURN_MAX = 20
) (
  input  logic       clk_2hz,
  input  logic       rst,
  input  logic       power_now,
  input  logic [3:0] state,
  input  logic       sw_left,
  input  logic       sw_right,
  input  logic       sw_back,
  input  logic       sw_fwd,
  output logic [3:0] answer,
  output logic       turn_active,
  output logic       blink_phase,
  output logic       cancel_pulse
);

  localparam int TW = $clog2(TURN_MAX + 1);

  logic deb_l, deb_r, deb_b, deb_f;
  logic drive_ok;

  fsm_t          fsm_q, fsm_d;
  logic [TW-1:0] timer_q, timer_d, timer_inc;
  logic [3:0]    answer_q, answer_d;
  logic          active_q, active_d;
  logic          blink_q, blink_d;
  logic          pulse_q, pulse_d;

  sw_debounce #(.DEB_CNT(DEB_CNT)) u_deb_left  (.clk_2hz(clk_2hz), .rst(rst), .clr_i(~power_now), .raw_i(sw_left),  .deb_o(deb_l));
  sw_debounce #(.DEB_CNT(DEB_CNT)) u_deb_right (.clk_2hz(clk_2hz), .rst(rst), .clr_i(~power_now), .raw_i(sw_right), .deb_o(deb_r));
  sw_debounce #(.DEB_CNT(DEB_CNT)) u_deb_back  (.clk_2hz(clk_2hz), .rst(rst), .clr_i(~power_now), .raw_i(sw_back),  .deb_o(deb_b));
  sw_debounce #(.DEB_CNT(DEB_CNT)) u_deb_fwd   (.clk_2hz(clk_2hz), .rst(rst), .clr_i(~power_now), .raw_i(sw_fwd),   .deb_o(deb_f));

  assign drive_ok  = power_now & ((state == ST_START) | (state == ST_MOVE));
  assign timer_inc = (timer_q == TW'(TURN_MAX)) ? timer_q : timer_q + 1'b1;

  always_comb begin
    fsm_d   = fsm_q;
    timer_d = timer_inc;
    pulse_d = 1'b0;
    case (fsm_q)
      IDLE: begin
        timer_d = '0;
        if (deb_l & ~deb_r)      fsm_d = TURN_L;
        else if (deb_r & ~deb_l) fsm_d = TURN_R;
`ifdef HAZARD_EN
        else if (deb_l & deb_r)  fsm_d = HAZARD;
`endif
      end
      TURN_L, TURN_R: begin
        // Release beats timeout when both land on the same edge
        if ((fsm_q == TURN_L) ? (~deb_l | deb_r) : (~deb_r | deb_l)) begin
          fsm_d   = IDLE;
          timer_d = '0;
        end else if (timer_q == TW'(TURN_MAX - 1)) begin
          fsm_d   = COOLDOWN;
          timer_d = '0;
          pulse_d = 1'b1;
        end
      end
      COOLDOWN: begin
        if ((timer_q != '0) && !deb_l && !deb_r) begin
          fsm_d   = IDLE;
          timer_d = '0;
        end
      end
`ifdef HAZARD_EN
      HAZARD: begin
        timer_d = '0;
        if (~deb_l | ~deb_r) fsm_d = IDLE;
      end
`endif
      default: begin
        fsm_d   = IDLE;
        timer_d = '0;
      end
    endcase
    if (!drive_ok) begin
      fsm_d   = IDLE;
      timer_d = '0;
      pulse_d = 1'b0;
    end
  end

  always_comb begin
    answer_d = '0;
    active_d = 1'b0;
`ifdef HAZARD_EN
    answer_d[ANS_LEFT]  = (fsm_d == TURN_L) | (fsm_d == HAZARD);
    answer_d[ANS_RIGHT] = (fsm_d == TURN_R) | (fsm_d == HAZARD);
    active_d            = (fsm_d == TURN_L) | (fsm_d == TURN_R) | (fsm_d == HAZARD);
`else
    answer_d[ANS_LEFT]  = (fsm_d == TURN_L);
    answer_d[ANS_RIGHT] = (fsm_d == TURN_R);
    active_d            = (fsm_d == TURN_L) | (fsm_d == TURN_R);
`endif
    if (drive_ok && !(deb_b && deb_f)) begin
      answer_d[ANS_BACK] = deb_b;
      answer_d[ANS_FWD]  = deb_f;
    end
    blink_d = active_d & (active_q ? ~blink_q : 1'b1);
  end

  always_ff @(posedge clk_2hz or negedge rst) begin
    if (!rst) begin
      fsm_q    <= IDLE;
      timer_q  <= '0;
      answer_q <= '0;
      active_q <= 1'b0;
      blink_q  <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      timer_q  <= timer_d;
      answer_q <= answer_d;
      active_q <= active_d;
      blink_q  <= blink_d;
      pulse_q  <= pulse_d;
    end
  end

  assign answer       = answer_q;
  assign turn_active  = active_q;
  assign blink_phase  = blink_q;
  assign cancel_pulse = pulse_q;

endmodule

// File: tb/tb_turn_cmd_encoder.sv
// Directed bench for turn_cmd_encoder with DEB_CNT=2, TURN_MAX=20.
module tb_turn_cmd_encoder;

  logic       clk_2hz = 1'b0;
  logic       rst = 1'b0;
  logic       power_now = 1'b0;
  logic [3:0] state = 4'b0001;
  logic       sw_left = 1'b0, sw_right = 1'b0, sw_back = 1'b0, sw_fwd = 1'b0;
  logic [3:0] answer;
  logic       turn_active, blink_phase, cancel_pulse;

  int n_cmp = 0;
  int n_fail = 0;

  turn_cmd_encoder #(.DEB_CNT(2), .TURN_MAX(20)) dut (
    .clk_2hz(clk_2hz), .rst(rst), .power_now(power_now), .state(state),
    .sw_left(sw_left), .sw_right(sw_right), .sw_back(sw_back), .sw_fwd(sw_fwd),
    .answer(answer), .turn_active(turn_active), .blink_phase(blink_phase),
    .cancel_pulse(cancel_pulse)
  );

  always #5 clk_2hz = ~clk_2hz;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_2hz);
      #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    #2;
    n_cmp++; if ({answer, turn_active, blink_phase, cancel_pulse} !== 7'b0) begin n_fail++; $display("FAIL reset_outputs: got %b want 0000000", {answer, turn_active, blink_phase, cancel_pulse}); end
    power_now = 1'b1;
    state = 4'b0100;
    tick(2);
    rst = 1'b1;
    tick(1);
    n_cmp++; if ({answer, turn_active, blink_phase, cancel_pulse} !== 7'b0) begin n_fail++; $display("FAIL reset_release: got %b want 0000000", {answer, turn_active, blink_phase, cancel_pulse}); end
  endtask

  task automatic test_left_turn;
    sw_left = 1'b1;
    tick(2);
    n_cmp++; if (answer !== 4'b0000) begin n_fail++; $display("FAIL left_edge2: answer=%b want 0000", answer); end
    tick(1);
    n_cmp++; if (answer !== 4'b1000) begin n_fail++; $display("FAIL left_edge3: answer=%b want 1000", answer); end
    n_cmp++; if (turn_active !== 1'b1) begin n_fail++; $display("FAIL left_active: got %b want 1", turn_active); end
    n_cmp++; if (blink_phase !== 1'b1) begin n_fail++; $display("FAIL left_blink0: got %b want 1", blink_phase); end
    tick(1);
    n_cmp++; if (blink_phase !== 1'b0) begin n_fail++; $display("FAIL left_blink1: got %b want 0", blink_phase); end
    tick(1);
    n_cmp++; if (blink_phase !== 1'b1) begin n_fail++; $display("FAIL left_blink2: got %b want 1", blink_phase); end
    sw_left = 1'b0;
    tick(2);
    n_cmp++; if (answer !== 4'b1000) begin n_fail++; $display("FAIL left_rel2: answer=%b want 1000", answer); end
    tick(1);
    n_cmp++; if ({answer, turn_active, blink_phase} !== 6'b000000) begin n_fail++; $display("FAIL left_rel3: got %b want 000000", {answer, turn_active, blink_phase}); end
  endtask

  task automatic test_timeout;
    sw_right = 1'b1;
    tick(3);
    n_cmp++; if (answer !== 4'b0100) begin n_fail++; $display("FAIL to_enter: answer=%b want 0100", answer); end
    tick(19);
    n_cmp++; if ({answer, cancel_pulse} !== 5'b01000) begin n_fail++; $display("FAIL to_last_cycle: got %b want 01000", {answer, cancel_pulse}); end
    tick(1);
    n_cmp++; if ({answer, turn_active, cancel_pulse} !== 6'b000001) begin n_fail++; $display("FAIL to_cancel: got %b want 000001", {answer, turn_active, cancel_pulse}); end
    tick(1);
    n_cmp++; if (cancel_pulse !== 1'b0) begin n_fail++; $display("FAIL to_pulse_width: got %b want 0", cancel_pulse); end
    for (int i = 0; i < 3; i++) begin
      tick(1);
      n_cmp++; if (answer !== 4'b0000) begin n_fail++; $display("FAIL to_cooldown_hold%0d: answer=%b want 0000", i, answer); end
    end
    sw_right = 1'b0;
    tick(3);
    n_cmp++; if (answer !== 4'b0000) begin n_fail++; $display("FAIL to_released: answer=%b want 0000", answer); end
    sw_right = 1'b1;
    tick(3);
    n_cmp++; if ({answer, blink_phase} !== 5'b01001) begin n_fail++; $display("FAIL to_rearm: got %b want 01001", {answer, blink_phase}); end
    sw_right = 1'b0;
    tick(3);
  endtask

  task automatic test_glitch;
    sw_left = 1'b1;
    tick(1);
    sw_left = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      n_cmp++; if (answer !== 4'b0000) begin n_fail++; $display("FAIL glitch%0d: answer=%b want 0000", i, answer); end
    end
  endtask

  task automatic test_state_drop;
    sw_left = 1'b1;
    tick(8);
    state = 4'b0001;
    tick(1);
    n_cmp++; if ({answer, turn_active, cancel_pulse} !== 6'b0) begin n_fail++; $display("FAIL drop_next_edge: got %b want 000000", {answer, turn_active, cancel_pulse}); end
    tick(2);
    n_cmp++; if ({answer, cancel_pulse} !== 5'b0) begin n_fail++; $display("FAIL drop_hold: got %b want 00000", {answer, cancel_pulse}); end
    state = 4'b0010;
    tick(1);
    n_cmp++; if (answer !== 4'b1000) begin n_fail++; $display("FAIL starting_ok: answer=%b want 1000", answer); end
    state = 4'b0110;
    tick(1);
    n_cmp++; if (answer !== 4'b0000) begin n_fail++; $display("FAIL non_onehot: answer=%b want 0000", answer); end
    sw_left = 1'b0;
    tick(3);
    state = 4'b0100;
    tick(1);
  endtask

  task automatic test_power_drop;
    sw_left = 1'b1;
    tick(3);
    power_now = 1'b0;
    tick(1);
    n_cmp++; if ({answer, cancel_pulse} !== 5'b0) begin n_fail++; $display("FAIL power_drop: got %b want 00000", {answer, cancel_pulse}); end
    power_now = 1'b1;
    tick(2);
    n_cmp++; if (answer !== 4'b0000) begin n_fail++; $display("FAIL power_redebounce: answer=%b want 0000", answer); end
    tick(1);
    n_cmp++; if (answer !== 4'b1000) begin n_fail++; $display("FAIL power_rearm: answer=%b want 1000", answer); end
    sw_left = 1'b0;
    tick(3);
  endtask

  task automatic test_rst_mid;
    sw_left = 1'b1;
    tick(13);
    n_cmp++; if (answer !== 4'b1000) begin n_fail++; $display("FAIL rst_pre: answer=%b want 1000", answer); end
    rst = 1'b0;
    #1;
    n_cmp++; if ({answer, turn_active, blink_phase, cancel_pulse} !== 7'b0) begin n_fail++; $display("FAIL rst_async: got %b want 0000000", {answer, turn_active, blink_phase, cancel_pulse}); end
    sw_left = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(1);
    sw_left = 1'b1;
    tick(2);
    n_cmp++; if (answer !== 4'b0000) begin n_fail++; $display("FAIL rst_redeb2: answer=%b want 0000", answer); end
    tick(1);
    n_cmp++; if (answer !== 4'b1000) begin n_fail++; $display("FAIL rst_rearm: answer=%b want 1000", answer); end
    sw_left = 1'b0;
    tick(3);
  endtask

  task automatic test_back_fwd;
    sw_back = 1'b1;
    tick(3);
    n_cmp++; if (answer !== 4'b0010) begin n_fail++; $display("FAIL back_only: answer=%b want 0010", answer); end
    sw_fwd = 1'b1;
    tick(3);
    n_cmp++; if (answer !== 4'b0000) begin n_fail++; $display("FAIL back_fwd_both: answer=%b want 0000", answer); end
    sw_back = 1'b0;
    tick(3);
    n_cmp++; if (answer !== 4'b0001) begin n_fail++; $display("FAIL fwd_only: answer=%b want 0001", answer); end
    state = 4'b1000;
    tick(1);
    n_cmp++; if (answer !== 4'b0000) begin n_fail++; $display("FAIL fwd_power_off: answer=%b want 0000", answer); end
    state = 4'b0100;
    sw_fwd = 1'b0;
    tick(3);
  endtask

  task automatic test_opposite;
    sw_left = 1'b1;
    tick(3);
    sw_right = 1'b1;
    tick(2);
    n_cmp++; if (answer !== 4'b1000) begin n_fail++; $display("FAIL opp_edge2: answer=%b want 1000", answer); end
    tick(1);
    n_cmp++; if (answer !== 4'b0000) begin n_fail++; $display("FAIL opp_exit: answer=%b want 0000", answer); end
    sw_left = 1'b0;
    sw_right = 1'b0;
    tick(4);
  endtask

  task automatic test_both;
    logic [3:0] exp_ans;
    logic       exp_act;
`ifdef HAZARD_EN
    exp_ans = 4'b1100;
    exp_act = 1'b1;
`else
    exp_ans = 4'b0000;
    exp_act = 1'b0;
`endif
    sw_left = 1'b1;
    sw_right = 1'b1;
    tick(3);
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if ({answer, turn_active} !== {exp_ans, exp_act}) begin n_fail++; $display("FAIL both_steady%0d: got %b want %b", i, {answer, turn_active}, {exp_ans, exp_act}); end
      tick(1);
    end
    sw_left = 1'b0;
    sw_right = 1'b0;
    tick(3);
    n_cmp++; if (answer !== 4'b0000) begin n_fail++; $display("FAIL both_release: answer=%b want 0000", answer); end
  endtask

  initial begin
    test_reset();
    test_left_turn();
    test_timeout();
    test_glitch();
    test_state_drop();
    test_power_drop();
    test_rst_mid();
    test_back_fwd();
    test_opposite();
    test_both();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
